regfile_writeback: RTL and testbench

- Write-side controller for the integer register file.
- Arbitrates retiring results from the single-cycle ALU path and the multi-cycle memory/long-latency path, and drives one registered write (we/rd/data) per cycle into the register file's write port.
- Keeps a per-register pending scoreboard. Issue logic uses it to stall read-after-write and write-after-write hazards on rs1/rs2/rd.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 44 ++++
 rtl/regfile_writeback.sv | 102 ++++++++++
 tb/tb_regfile_writeback.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and retire-request type for the register-file write side
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with set/clear and three lookup ports
module regfile_scoreboard #(
  parameter int  NREG = regfile_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] q1,
  input  logic [AW-1:0] q2,
  input  logic [AW-1:0] qd,
  output logic          busy1,
  output logic          busy2,
  output logic          busyd
);
  import regfile_pkg::*;

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;

  // Set is applied after clear so a new producer of the same register wins.
  always_comb begin
    sb_next = sb;
    if (clr_en) sb_next[clr_rd] = 1'b0;
    if (set_en) sb_next[set_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  assign busy1 = sb[q1];
  assign busy2 = sb[q2];
  assign busyd = sb[qd];

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - retire arbiter (memory over ALU), registered write port, hazard tracking
// Define REGFILE_WB_BYPASS_EN to add fwd1_o/fwd2_o forwarding of the write-cycle value.
module regfile_writeback #(
  parameter int  XLEN = regfile_pkg::XLEN,
  parameter int  NREG = regfile_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [AW-1:0]   alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [AW-1:0]   mem_rd_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            issue_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic            busy1_o,
  output logic            busy2_o,
  output logic            busyd_o,
  output logic            we_o,
  output logic [AW-1:0]   rd_o,
  output logic [XLEN-1:0] data_o
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic [XLEN-1:0] fwd1_o,
  output logic [XLEN-1:0] fwd2_o
`endif
);
  import regfile_pkg::*;

  wb_req_t win;
  logic    sb1;
  logic    sb2;
  logic    hit1;
  logic    hit2;

  assign mem_ready_o = 1'b1;
  assign alu_ready_o = !mem_valid_i;

  always_comb begin
    win = '0;
    if (mem_valid_i) begin
      win.valid = 1'b1;
      win.rd    = mem_rd_i;
      win.data  = mem_data_i;
    end else if (alu_valid_i) begin
      win.valid = 1'b1;
      win.rd    = alu_rd_i;
      win.data  = alu_data_i;
    end
  end

  // rd_o/data_o only move on a real write, so x0 retires leave the port untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_o   <= 1'b0;
      rd_o   <= '0;
      data_o <= '0;
    end else begin
      we_o <= win.valid && (win.rd != '0);
      if (win.valid && (win.rd != '0)) begin
        rd_o   <= win.rd;
        data_o <= win.data;
      end
    end
  end

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .set_en (issue_i && (issue_rd_i != '0)),
    .set_rd (issue_rd_i),
    .clr_en (win.valid),
    .clr_rd (win.rd),
    .q1     (rs1_i),
    .q2     (rs2_i),
    .qd     (issue_rd_i),
    .busy1  (sb1),
    .busy2  (sb2),
    .busyd  (busyd_o)
  );

  // The register file returns the old value during its write cycle.
  assign hit1 = we_o && (rd_o == rs1_i) && (rs1_i != '0);
  assign hit2 = we_o && (rd_o == rs2_i) && (rs2_i != '0);

`ifdef REGFILE_WB_BYPASS_EN
  assign busy1_o = sb1;
  assign busy2_o = sb2;
  assign fwd1_o  = hit1 ? data_o : '0;
  assign fwd2_o  = hit2 ? data_o : '0;
`else
  assign busy1_o = sb1 || hit1;
  assign busy2_o = sb2 || hit2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback (REGFILE_WB_BYPASS_EN aware)
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2, rd_o;
  logic [31:0] alu_data, mem_data, data_o;
  logic        issue, busy1, busy2, busyd, we_o;
`ifdef REGFILE_WB_BYPASS_EN
  logic [31:0] fwd1, fwd2;
`endif

  int passed = 0;
  int total  = 0;
  logic [36:0] exp_q[$];
  logic [31:0] pend, pend_next;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .issue_i(issue), .issue_rd_i(issue_rd), .rs1_i(rs1), .rs2_i(rs2),
    .busy1_o(busy1), .busy2_o(busy2), .busyd_o(busyd),
    .we_o(we_o), .rd_o(rd_o), .data_o(data_o)
`ifdef REGFILE_WB_BYPASS_EN
    , .fwd1_o(fwd1), .fwd2_o(fwd2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Monitor: every write presented must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_rd", 32'(rd_o), 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("write_rd", 32'(rd_o), 32'(e[36:32]));
        chk("write_data", data_o, e[31:0]);
      end
    end
  end

  // Pending model used only to police the upstream contract.
  always_comb begin
    pend_next = pend;
    if (mem_valid) pend_next[mem_rd] = 1'b0;
    else if (alu_valid) pend_next[alu_rd] = 1'b0;
    if (issue) pend_next[issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else pend <= pend_next;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(issue && busyd &&
                !((mem_valid && mem_rd == issue_rd) ||
                  (!mem_valid && alu_valid && alu_rd == issue_rd))))
        else $error("contract: issue while destination pending");
      assert (!(mem_valid && mem_rd != 5'd0 && !pend[mem_rd]))
        else $error("contract: mem retire to idle register");
      assert (!(!mem_valid && alu_valid && alu_rd != 5'd0 && !pend[alu_rd]))
        else $error("contract: alu retire to idle register");
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue = 0; issue_rd = 0; rs1 = 0; rs2 = 0;

    #2;
    chk("reset_we", 32'(we_o), 32'd0);
    chk("reset_rd", 32'(rd_o), 32'd0);
    chk("reset_data", data_o, 32'd0);
    chk("reset_mem_ready", 32'(mem_ready), 32'd1);
    chk("reset_alu_ready_idle", 32'(alu_ready), 32'd1);
    mem_valid = 1;
    #1 chk("reset_alu_ready_memvalid", 32'(alu_ready), 32'd0);
    mem_valid = 0;
    #10 rst_n = 1'b1;
    cyc();

    // Reset asserted mid-traffic while a write is on the port.
    issue = 1; issue_rd = 5; cyc();
    issue_rd = 6; cyc();
    issue = 0; mem_valid = 1; mem_rd = 5; mem_data = 32'hDEAD; rs1 = 6;
    #1 chk("busy1_rs6_pending", 32'(busy1), 32'd1);
    push(5, 32'hDEAD);
    cyc();
    mem_rd = 6; mem_data = 32'hBEEF;
    #1 chk("we_before_reset", 32'(we_o), 32'd1);
    #5 rst_n = 1'b0;
    #1 chk("we_async_reset", 32'(we_o), 32'd0);
    chk("busy1_rs6_reset", 32'(busy1), 32'd0);
    rs1 = 5;
    #1 chk("busy1_rs5_reset", 32'(busy1), 32'd0);
    cyc();
    mem_valid = 0;
    #2 rst_n = 1'b1;
    cyc(); cyc();
    chk("no_write_after_reset", 32'(we_o), 32'd0);

    // Single ALU retire with read-timing busy window.
    issue = 1; issue_rd = 3; rs1 = 3; cyc();
    issue = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'h1234;
    #1 chk("alu_ready_single", 32'(alu_ready), 32'd1);
    chk("busy1_N", 32'(busy1), 32'd1);
    push(3, 32'h1234);
    cyc();
    alu_valid = 0;
    #1 chk("single_we", 32'(we_o), 32'd1);
    chk("single_rd", 32'(rd_o), 32'd3);
    chk("single_data", data_o, 32'h1234);
`ifdef REGFILE_WB_BYPASS_EN
    chk("busy1_N1_bypass", 32'(busy1), 32'd0);
    chk("fwd1_N1", fwd1, 32'h1234);
`else
    chk("busy1_N1", 32'(busy1), 32'd1);
`endif
    cyc();
    #1 chk("busy1_N2", 32'(busy1), 32'd0);
    chk("single_we_drop", 32'(we_o), 32'd0);

    // Collision: memory wins, ALU retires the following cycle.
    issue = 1; issue_rd = 4; cyc();
    issue_rd = 6; cyc();
    issue = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 32'hA;
    mem_valid = 1; mem_rd = 6; mem_data = 32'hB;
    #1 chk("coll_mem_ready", 32'(mem_ready), 32'd1);
    chk("coll_alu_ready", 32'(alu_ready), 32'd0);
    push(6, 32'hB);
    cyc();
    mem_valid = 0;
    #1 chk("coll_alu_ready_next", 32'(alu_ready), 32'd1);
    chk("coll_first_rd", 32'(rd_o), 32'd6);
    push(4, 32'hA);
    cyc();
    alu_valid = 0;
    #1 chk("coll_second_rd", 32'(rd_o), 32'd4);
    chk("coll_second_data", data_o, 32'hA);
    cyc();

    // x0 retire is accepted but never written.
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF; rs1 = 0;
    #1 chk("x0_alu_ready", 32'(alu_ready), 32'd1);
    chk("x0_busy1", 32'(busy1), 32'd0);
    cyc();
    alu_valid = 0;
    #1 chk("x0_we", 32'(we_o), 32'd0);
    chk("x0_busy1_next", 32'(busy1), 32'd0);
    cyc();

    // Same-register set and clear in one cycle: new producer wins.
    issue = 1; issue_rd = 7; cyc();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    #1 chk("setclr_busyd_before", 32'(busyd), 32'd1);
    push(7, 32'h77);
    cyc();
    issue = 0; alu_valid = 0;
    #1 chk("setclr_busyd_after", 32'(busyd), 32'd1);

    // Different registers set and cleared together.
    issue = 1; issue_rd = 8; alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    push(7, 32'h78);
    cyc();
    issue = 0; alu_valid = 0; issue_rd = 7; rs1 = 7; rs2 = 8;
    #1 chk("diff_busy2_set", 32'(busy2), 32'd1);
    chk("diff_busyd_clear", 32'(busyd), 32'd0);
    cyc();
    #1 chk("diff_busy1_done", 32'(busy1), 32'd0);
    alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
    push(8, 32'h88);
    cyc();
    alu_valid = 0;
    cyc();

    // Forwarding window on rs2.
    issue = 1; issue_rd = 9; cyc();
    issue = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h55; rs2 = 9;
    push(9, 32'h55);
    cyc();
    alu_valid = 0;
`ifdef REGFILE_WB_BYPASS_EN
    #1 chk("bypass_busy2", 32'(busy2), 32'd0);
    chk("bypass_fwd2", fwd2, 32'h55);
    chk("bypass_fwd1_nomatch", fwd1, 32'd0);
`else
    #1 chk("nobypass_busy2", 32'(busy2), 32'd1);
`endif
    cyc();
    #1 chk("busy2_after_write", 32'(busy2), 32'd0);

    cyc(); cyc();
    chk("expected_writes_left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
